// File: rtl/instr_queue_pkg.sv
// Shared types and constants for the dual-issue instruction queue.
package instr_queue_pkg;

  localparam int DATA_WIDTH = 32;

  // Canonical RISC-V NOP (addi x0, x0, 0), shown in any slot without a real entry.
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue_if.sv
// Fetch-side push and decode-side pop signals of the instruction queue.
interface instr_queue_if #(
  parameter int DEPTH = 8
);
  import instr_queue_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: a push happens on a rising edge when wr_valid && wr_ready. wr_ready is
  // a function of the registered occupancy only, so fetch may act on it without
  // looking at rd_pop. rd_pop (0..2) needs no handshake: it is clamped to the
  // occupancy, and validA/validB tell decode how many entries it may consume.
  logic                  wr_valid;
  logic                  wr_two;
  logic [DATA_WIDTH-1:0] wr_instrA;
  logic [DATA_WIDTH-1:0] wr_pcA;
  logic [DATA_WIDTH-1:0] wr_instrB;
  logic [DATA_WIDTH-1:0] wr_pcB;
  logic                  wr_ready;
  logic [1:0]            rd_pop;
  logic [DATA_WIDTH-1:0] instrA;
  logic [DATA_WIDTH-1:0] pcA;
  logic                  validA;
  logic [DATA_WIDTH-1:0] instrB;
  logic [DATA_WIDTH-1:0] pcB;
  logic                  validB;
  logic [CW-1:0]         count;

  modport master (
    output wr_valid, wr_two, wr_instrA, wr_pcA, wr_instrB, wr_pcB, rd_pop,
    input  wr_ready, instrA, pcA, validA, instrB, pcB, validB, count
  );

  modport slave (
    input  wr_valid, wr_two, wr_instrA, wr_pcA, wr_instrB, wr_pcB, rd_pop,
    output wr_ready, instrA, pcA, validA, instrB, pcB, validB, count
  );

endinterface

// File: rtl/instr_queue_storage.sv
// Entry array of the instruction queue: two write ports, two combinational read ports.
module iq_storage
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      we0,
  input  logic [IW-1:0] widx0,
  input  iq_entry_t wdata0,
  input  logic      we1,
  input  logic [IW-1:0] widx1,
  input  iq_entry_t wdata1,
  input  logic [IW-1:0] ridx0,
  output iq_entry_t rdata0,
  input  logic [IW-1:0] ridx1,
  output iq_entry_t rdata1
);

  // No reset: contents are only ever seen through slots the control marks valid.
  iq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem[widx0] <= wdata0;
    if (we1) mem[widx1] <= wdata1;
  end

  assign rdata0 = mem[ridx0];
  assign rdata1 = mem[ridx1];

endmodule

// File: rtl/instr_queue.sv
// Dual-issue instruction queue: pointer/occupancy control, push/pop/flush and slot masking.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  instr_queue_if.slave  q
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  // Pointers carry one extra MSB so full (count==DEPTH) and empty differ.
  logic [PW-1:0] rd_ptr, wr_ptr, count, pop_n, push_n;
  logic [1:0]    pop_req;
  logic          push, clear;
  logic [IW-1:0] widx0, widx1, ridx0, ridx1;
  iq_entry_t     rd_a, rd_b;

  assign count  = wr_ptr - rd_ptr;
  assign clear  = rst || flush;

  assign q.count    = count;
  assign q.wr_ready = (count <= PW'(DEPTH - 2));

  assign push    = q.wr_valid && q.wr_ready;
  assign pop_req = (q.rd_pop == 2'd3) ? 2'd2 : q.rd_pop;
  assign pop_n   = (PW'(pop_req) > count) ? count : PW'(pop_req);
  assign push_n  = push ? (q.wr_two ? PW'(2) : PW'(1)) : '0;

  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      rd_ptr <= rd_ptr + pop_n;
      wr_ptr <= wr_ptr + push_n;
    end
  end

  rd_pop_legal: assert property (@(posedge clk) disable iff (rst) q.rd_pop != 2'd3);

  // Index arithmetic is IW bits wide, so a pair straddling the wrap lands at DEPTH-1 and 0.
  assign widx0 = wr_ptr[IW-1:0];
  assign widx1 = widx0 + IW'(1);
  assign ridx0 = rd_ptr[IW-1:0];
  assign ridx1 = ridx0 + IW'(1);

  iq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk    (clk),
    .we0    (push && !clear),
    .widx0  (widx0),
    .wdata0 ('{instr: q.wr_instrA, pc: q.wr_pcA}),
    .we1    (push && q.wr_two && !clear),
    .widx1  (widx1),
    .wdata1 ('{instr: q.wr_instrB, pc: q.wr_pcB}),
    .ridx0  (ridx0),
    .rdata0 (rd_a),
    .ridx1  (ridx1),
    .rdata1 (rd_b)
  );

  assign q.validA = (count != '0);
  assign q.validB = (count >= PW'(2));
  assign q.instrA = q.validA ? rd_a.instr : NOP_INSTR;
  assign q.pcA    = q.validA ? rd_a.pc    : '0;
  assign q.instrB = q.validB ? rd_b.instr : NOP_INSTR;
  assign q.pcB    = q.validB ? rd_b.pc    : '0;

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed vector table plus random traffic against a queue model.
module tb_instr_queue;
  import instr_queue_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  instr_queue_if #(.DEPTH(DEPTH)) q();
  instr_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .flush(flush), .q(q.slave));

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  logic m_rdy, obs_rdy;

  typedef struct {
    logic r, f, wv, two;
    logic [31:0] ia, pa, ib, pb;
    logic [1:0]  pop;
    logic        e_rdy;
    logic [3:0]  e_cnt;
    logic        e_va;
    logic [31:0] e_ia, e_pa;
    logic        e_vb;
    logic [31:0] e_pb;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'h0000_0093 | (pc << 12);
  endfunction

  function automatic vec_t mkv(input logic r, f, wv, two,
                               input logic [31:0] pa, pb, input logic [1:0] pop,
                               input logic e_rdy, input logic [3:0] e_cnt,
                               input logic e_va, input logic [31:0] e_pa,
                               input logic e_vb, input logic [31:0] e_pb);
    vec_t v;
    v.r = r; v.f = f; v.wv = wv; v.two = two;
    v.ia = ins(pa); v.pa = pa; v.ib = ins(pb); v.pb = pb; v.pop = pop;
    v.e_rdy = e_rdy; v.e_cnt = e_cnt; v.e_va = e_va;
    v.e_ia = e_va ? ins(e_pa) : NOP_INSTR;
    v.e_pa = e_va ? e_pa : 32'h0;
    v.e_vb = e_vb; v.e_pb = e_vb ? e_pb : 32'h0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, record wr_ready before the edge, advance the model.
  task automatic step(input logic r, f, wv, two,
                      input logic [31:0] ia, pa, ib, pb, input logic [1:0] pop);
    @(negedge clk);
    rst = r; flush = f;
    q.wr_valid = wv; q.wr_two = two;
    q.wr_instrA = ia; q.wr_pcA = pa; q.wr_instrB = ib; q.wr_pcB = pb;
    q.rd_pop = pop;
    #1;
    obs_rdy = q.wr_ready;
    m_rdy   = (DEPTH - exp_q.size()) >= 2;
    @(posedge clk);
    if (r || f) begin
      exp_q.delete();
    end else begin
      int n;
      n = (int'(pop) > exp_q.size()) ? exp_q.size() : int'(pop);
      repeat (n) void'(exp_q.pop_front());
      if (wv && m_rdy) begin
        exp_q.push_back({ia, pa});
        if (two) exp_q.push_back({ib, pb});
      end
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = exp_q.size();
    check({tag, ".wr_ready"}, 32'(obs_rdy), 32'(m_rdy));
    check({tag, ".count"},  32'(q.count),  32'(sz));
    check({tag, ".validA"}, 32'(q.validA), 32'(sz >= 1));
    check({tag, ".instrA"}, q.instrA, (sz >= 1) ? exp_q[0][63:32] : NOP_INSTR);
    check({tag, ".pcA"},    q.pcA,    (sz >= 1) ? exp_q[0][31:0]  : 32'h0);
    check({tag, ".validB"}, 32'(q.validB), 32'(sz >= 2));
    check({tag, ".instrB"}, q.instrB, (sz >= 2) ? exp_q[1][63:32] : NOP_INSTR);
    check({tag, ".pcB"},    q.pcB,    (sz >= 2) ? exp_q[1][31:0]  : 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst = 1'b1; flush = 1'b0;
    q.wr_valid = 1'b0; q.wr_two = 1'b0; q.rd_pop = 2'd0;
    q.wr_instrA = '0; q.wr_pcA = '0; q.wr_instrB = '0; q.wr_pcB = '0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset then idle: empty queue with NOP slots every cycle.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("idle.wr_ready", 32'(obs_rdy), 32'd1);
      check("idle.count", 32'(q.count), 32'd0);
      check("idle.validA", 32'(q.validA), 32'd0);
      check("idle.validB", 32'(q.validB), 32'd0);
      check("idle.instrA", q.instrA, NOP_INSTR);
      check("idle.instrB", q.instrB, NOP_INSTR);
      check("idle.pcA", q.pcA, 32'h0);
    end

    //           r f wv 2  pa      pb      pop rdy cnt vA pcA     vB pcB
    tbl.push_back(mkv(0,0,1,1, 32'h0,   32'h4,   0, 1, 2, 1, 32'h0,   1, 32'h4));
    tbl[0].ia = 32'h0050_0093; tbl[0].ib = 32'h00A0_0113; tbl[0].e_ia = 32'h0050_0093;
    tbl.push_back(mkv(0,0,0,0, 32'h0,   32'h0,   2, 1, 0, 0, 32'h0,   0, 32'h0));
    tbl.push_back(mkv(0,0,1,1, 32'h10,  32'h14,  0, 1, 2, 1, 32'h10,  1, 32'h14));
    tbl.push_back(mkv(0,0,1,1, 32'h18,  32'h1c,  0, 1, 4, 1, 32'h10,  1, 32'h14));
    tbl.push_back(mkv(0,0,1,1, 32'h20,  32'h24,  0, 1, 6, 1, 32'h10,  1, 32'h14));
    tbl.push_back(mkv(0,0,1,0, 32'h28,  32'h2c,  0, 1, 7, 1, 32'h10,  1, 32'h14));
    tbl.push_back(mkv(0,0,1,1, 32'h30,  32'h34,  0, 0, 7, 1, 32'h10,  1, 32'h14));
    tbl.push_back(mkv(0,0,1,0, 32'h38,  32'h3c,  0, 0, 7, 1, 32'h10,  1, 32'h14));
    tbl.push_back(mkv(0,0,0,0, 32'h0,   32'h0,   2, 0, 5, 1, 32'h18,  1, 32'h1c));
    tbl.push_back(mkv(0,0,0,0, 32'h0,   32'h0,   2, 1, 3, 1, 32'h20,  1, 32'h24));
    tbl.push_back(mkv(0,0,1,1, 32'h30,  32'h34,  1, 1, 4, 1, 32'h24,  1, 32'h28));
    tbl.push_back(mkv(0,0,0,0, 32'h0,   32'h0,   2, 1, 2, 1, 32'h30,  1, 32'h34));
    tbl.push_back(mkv(0,0,0,0, 32'h0,   32'h0,   1, 1, 1, 1, 32'h34,  0, 32'h0));
    tbl.push_back(mkv(0,0,0,0, 32'h0,   32'h0,   2, 1, 0, 0, 32'h0,   0, 32'h0));
    tbl.push_back(mkv(0,0,1,1, 32'h40,  32'h44,  0, 1, 2, 1, 32'h40,  1, 32'h44));
    tbl.push_back(mkv(0,0,1,1, 32'h48,  32'h4c,  2, 1, 2, 1, 32'h48,  1, 32'h4c));
    tbl.push_back(mkv(0,0,0,0, 32'h0,   32'h0,   2, 1, 0, 0, 32'h0,   0, 32'h0));
    tbl.push_back(mkv(0,0,1,1, 32'h100, 32'h104, 0, 1, 2, 1, 32'h100, 1, 32'h104));
    tbl.push_back(mkv(0,0,0,0, 32'h0,   32'h0,   1, 1, 1, 1, 32'h104, 0, 32'h0));
    tbl.push_back(mkv(0,0,0,0, 32'h0,   32'h0,   1, 1, 0, 0, 32'h0,   0, 32'h0));
    tbl.push_back(mkv(0,0,1,1, 32'h200, 32'h204, 0, 1, 2, 1, 32'h200, 1, 32'h204));
    tbl.push_back(mkv(0,0,1,1, 32'h208, 32'h20c, 0, 1, 4, 1, 32'h200, 1, 32'h204));
    tbl.push_back(mkv(0,0,1,0, 32'h210, 32'h214, 0, 1, 5, 1, 32'h200, 1, 32'h204));
    tbl.push_back(mkv(0,1,1,1, 32'h218, 32'h21c, 2, 1, 0, 0, 32'h0,   0, 32'h0));
    tbl.push_back(mkv(0,0,0,0, 32'h0,   32'h0,   0, 1, 0, 0, 32'h0,   0, 32'h0));
    tbl.push_back(mkv(0,0,1,1, 32'h300, 32'h304, 0, 1, 2, 1, 32'h300, 1, 32'h304));
    tbl.push_back(mkv(1,0,1,1, 32'h308, 32'h30c, 1, 1, 0, 0, 32'h0,   0, 32'h0));
    tbl.push_back(mkv(0,0,0,0, 32'h0,   32'h0,   0, 1, 0, 0, 32'h0,   0, 32'h0));
    tbl.push_back(mkv(0,0,1,0, 32'h400, 32'h404, 0, 1, 1, 1, 32'h400, 0, 32'h0));

    foreach (tbl[i]) begin
      v = tbl[i];
      step(v.r, v.f, v.wv, v.two, v.ia, v.pa, v.ib, v.pb, v.pop);
      check($sformatf("vec%0d.wr_ready", i), 32'(obs_rdy), 32'(v.e_rdy));
      check($sformatf("vec%0d.count", i), 32'(q.count), 32'(v.e_cnt));
      check($sformatf("vec%0d.validA", i), 32'(q.validA), 32'(v.e_va));
      check($sformatf("vec%0d.instrA", i), q.instrA, v.e_ia);
      check($sformatf("vec%0d.pcA", i), q.pcA, v.e_pa);
      check($sformatf("vec%0d.validB", i), 32'(q.validB), 32'(v.e_vb));
      check($sformatf("vec%0d.pcB", i), q.pcB, v.e_pb);
    end

    // Random traffic: mixed push/pop rates with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      logic r, f, wv, two;
      logic [1:0] pop;
      r   = ($urandom_range(0, 99) == 0);
      f   = ($urandom_range(0, 39) == 0);
      wv  = ($urandom_range(0, 9) < 7);
      two = $urandom_range(0, 1);
      pop = 2'($urandom_range(0, 2));
      step(r, f, wv, two, $urandom, $urandom, $urandom, $urandom, pop);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
